// File: rtl/clk_div_gate_if.sv
// clk_div_gate_if: control and status bundle of the clock divider/gate (pcnt present with CLK_DIV_PCNT_EN)
interface clk_div_gate_if #(parameter int CNT_W = 8);
  logic             ena;
  logic [CNT_W-1:0] div;
  logic             load;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] div_act;
`ifdef CLK_DIV_PCNT_EN
  logic [15:0]      pcnt;
`endif
  modport master (
    output ena, div, load,
`ifdef CLK_DIV_PCNT_EN
    input  pcnt,
`endif
    input  clk_out, tick, busy, div_act
  );
  modport slave (
    input  ena, div, load,
`ifdef CLK_DIV_PCNT_EN
    output pcnt,
`endif
    output clk_out, tick, busy, div_act
  );
endinterface

// File: rtl/clk_div_gate.sv
// clk_div_gate: glitch-free programmable divider/gate with graceful stop; CLK_DIV_PCNT_EN adds a period counter
module clk_div_gate #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 4
) (
  input logic         clk,
  input logic         rst,
  clk_div_gate_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, shadow, shadow_nx, act, act_nx, cap;
  logic [CNT_W:0]   half;
  logic             co, co_nx, tk, tk_nx, wrap;
  always_comb begin
    cap       = bus.div < CNT_W'(2) ? CNT_W'(2) : bus.div;
    wrap      = state != IDLE && cnt == act - 1'b1;
    shadow_nx = bus.load ? cap : shadow;
    act_nx    = (state == IDLE && bus.load) || wrap ? shadow_nx : act;
    state_nx  = bus.ena ? RUN : state == RUN ? DRAIN : (state == DRAIN && wrap) ? IDLE : state;
    cnt_nx    = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
    half      = ({1'b0, act_nx} + 1'b1) >> 1;
    co_nx     = state_nx != IDLE && {1'b0, cnt_nx} < half;
    tk_nx     = state_nx != IDLE && cnt_nx == act_nx - 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= CNT_W'(DIV_RST);
      act    <= CNT_W'(DIV_RST);
      co     <= 1'b0;
      tk     <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= state_nx == IDLE ? '0 : cnt_nx;
      shadow <= shadow_nx;
      act    <= act_nx;
      co     <= co_nx;
      tk     <= tk_nx;
    end
  assign bus.clk_out = co;
  assign bus.tick    = tk;
  assign bus.busy    = state != IDLE;
  assign bus.div_act = act;
`ifdef CLK_DIV_PCNT_EN
  logic [15:0] pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= '0;
    else if (state == IDLE && state_nx == RUN) pc <= '0;
    else if (wrap && pc != 16'hFFFF) pc <= pc + 1'b1;
  assign bus.pcnt = pc;
`endif
endmodule

// File: tb/tb_clk_div_gate.sv
// tb_clk_div_gate: randomized and directed checks of clk_div_gate against a period-level model
module tb_clk_div_gate;
  logic clk = 1'b0;
  logic rst = 1'b0;
  clk_div_gate_if #(.CNT_W(8)) bus();
  clk_div_gate #(.CNT_W(8), .DIV_RST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int m_pos, m_n, m_sh, m_pc;
  bit m_act, m_stop, ena_r;
  logic [7:0] pat, tpat;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset;
    m_pos = 0; m_n = 4; m_sh = 4; m_pc = 0; m_act = 0; m_stop = 0;
  endtask
  // One oscillator edge: a period is a run of m_n positions; stopping only ends a period
  task automatic m_step(bit ena, bit load, int div);
    int c;
    bit last;
    c = div < 2 ? 2 : div;
    if (!m_act) begin
      if (load) begin m_sh = c; m_n = c; end
      if (ena) begin m_act = 1; m_stop = 0; m_pos = 0; m_pc = 0; end
    end else begin
      last = m_pos == m_n - 1;
      if (load) m_sh = c;
      if (last) begin
        m_pos = 0;
        m_n = m_sh;
        if (m_pc < 65535) m_pc++;
        if (m_stop && !ena) m_act = 0;
      end else m_pos++;
      m_stop = !ena;
    end
  endtask
  task automatic compare;
    check("clk_out", bus.clk_out, m_act && m_pos < (m_n + 1) / 2);
    check("tick", bus.tick, m_act && m_pos == m_n - 1);
    check("busy", bus.busy, m_act);
    check("div_act", bus.div_act, m_n);
`ifdef CLK_DIV_PCNT_EN
    check("pcnt", bus.pcnt, m_pc);
`endif
  endtask
  task automatic cycle(bit ena, bit load, int div);
    bus.ena = ena; bus.load = load; bus.div = 8'(div);
    m_step(ena, load, div);
    @(negedge clk);
    pat = {pat[6:0], bus.clk_out};
    tpat = {tpat[6:0], bus.tick};
    compare();
  endtask
  task automatic pulse_rst;
    #2 rst = 1'b1;
    #1 m_reset();
    compare();
    @(negedge clk);
    rst = 1'b0;
    compare();
  endtask
  initial begin
    bus.ena = 0; bus.load = 0; bus.div = 0;
    m_reset();
    #1 rst = 1'b1;
    #1 compare();
    @(negedge clk);
    rst = 1'b0;
    compare();
    repeat (8) cycle(1, 0, 0);
    check("t1_clk_pattern", pat, 8'hCC);
    check("t1_tick_pattern", tpat, 8'h11);
    cycle(1, 0, 0);
    cycle(1, 1, 5);
    repeat (7) cycle(1, 0, 0);
    check("t2_clk_pattern", pat[6:0], 7'h1C);
    check("t2_div_act", bus.div_act, 5);
    pulse_rst();
    cycle(0, 1, 6);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    repeat (6) cycle(0, 0, 0);
    check("t3_clk_pattern", pat, 8'hE0);
    check("t3_busy", bus.busy, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    repeat (8) cycle(1, 0, 0);
    repeat (14) cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    check("t5_div_act", bus.div_act, 2);
    repeat (8) cycle(1, 0, 0);
    check("t5_clk_pattern", pat, 8'hAA);
    check("t5_tick_pattern", tpat, 8'h55);
    pulse_rst();
    cycle(0, 1, 8);
    repeat (3) cycle(1, 0, 0);
    pulse_rst();
    check("t6_clk_after_rst", bus.clk_out, 0);
    cycle(0, 1, 2);
    repeat (7) cycle(1, 0, 0);
`ifdef CLK_DIV_PCNT_EN
    check("t6_pcnt", bus.pcnt, 3);
`endif
    ena_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ena_r = !ena_r;
      if ($urandom_range(0, 299) == 0) pulse_rst();
      cycle(ena_r, $urandom_range(0, 5) == 0,
            $urandom_range(0, 49) == 0 ? $urandom_range(0, 40) : $urandom_range(0, 9));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clk_div_gate.md
Name: clk_div_gate

Overview:
- Programmable clock divider and gate placed directly downstream of the ring oscillator; it consumes the oscillator's CLK as its only clock.
- Produces a glitch-free divided clock CLK_OUT plus a one-cycle period-boundary strobe TICK for synchronous logic.
- Start and stop follow ENA. Stops are graceful: a period is never truncated.
- Divide ratio is reloadable while running; a new ratio takes effect only at a period boundary.

Parameters:
- CNT_W, 8: width of divide ratio and internal counter.
- DIV_RST, 4: divide ratio loaded at reset; must be >= 2.

Ports:
- CLK  in  1  oscillator clock; all flops on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENA  in  1  run request, level-sensitive, sampled on CLK.
- DIV  in  CNT_W  requested divide ratio N.
- LOAD  in  1  one-cycle strobe; captures DIV into shadow register.
- CLK_OUT  out  1  divided clock, registered.
- TICK  out  1  high for the cycle in which the last counter state of a period is held.
- BUSY  out  1  high while state != IDLE.
- DIV_ACT  out  CNT_W  ratio currently in effect.

Behaviour:
- Reset (async, RST=1): state=IDLE, cnt=0, CLK_OUT=0, TICK=0, BUSY=0, shadow=DIV_ACT=DIV_RST.
- Ratio clamp: captured DIV values 0 or 1 are stored as 2, so N always >= 2.
- High time H=ceil(N/2); low time N-H. CLK_OUT=1 while cnt<H, else 0. All outputs are registered.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cnt=0, CLK_OUT=0, TICK=0.
  - LOAD captures DIV into shadow and DIV_ACT on the same edge.
  - ENA=1 at an edge -> RUN; that edge sets cnt=0, CLK_OUT=1. Latency from ENA sample to CLK_OUT high is 1 edge.
- RUN:
  - cnt increments each edge, wrapping from N-1 to 0.
  - TICK=1 exactly while cnt==N-1.
  - Wrap edge (period boundary): DIV_ACT <- shadow, and the new N governs the next period.
  - ENA=0 -> DRAIN. Counting continues unchanged.
- DRAIN:
  - Counting continues unchanged.
  - At the wrap edge with ENA=0 -> IDLE; CLK_OUT stays 0, TICK=0, BUSY=0.
  - ENA=1 again before the wrap -> RUN with no interruption of CLK_OUT.
- LOAD while RUN/DRAIN: shadow updated. Multiple LOADs in one period: last wins.
- LOAD on the same edge as the wrap: the newly captured value is applied at that wrap (shadow bypass).
- CLK_OUT has no pulse shorter than min(H, N-H) CLK cycles under any ENA/LOAD sequence.
- RST mid-period forces immediate reset values. Truncation is allowed only under reset.
- cnt width is CNT_W. No arithmetic overflow, since cnt <= N-1 <= 2^CNT_W-1.

Optional Feature:
- Macro: CLK_DIV_PCNT_EN.
- Defined:
  - Adds output PCNT (16 bits): count of completed periods, incremented at each wrap edge in RUN/DRAIN.
  - Saturates at 16'hFFFF. Cleared by RST and on the IDLE->RUN transition.
  - Holds its value in IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, N=4, ENA=1 -> CLK_OUT pattern 1,1,0,0 repeating; TICK high every 4th cycle, coincident with the 2nd low cycle; BUSY=1.
2. LOAD DIV=5 mid-period of N=4 -> current period finishes as 4 cycles; next period is 1,1,1,0,0; DIV_ACT=5 from the wrap edge.
3. Drop ENA at cnt=1, N=6 -> CLK_OUT completes 1,1,1,0,0,0 then holds 0; BUSY falls on the wrap edge; state=IDLE.
4. Drop ENA at cnt=1, reassert at cnt=3, N=6 -> CLK_OUT continues with no gap; BUSY stays 1.
5. LOAD DIV=0 then DIV=1 in IDLE -> DIV_ACT=2; run gives CLK_OUT 1,0 alternating; TICK on every low cycle.
6. RST pulse at cnt=2, N=8 while running -> outputs go to reset values immediately. With CLK_DIV_PCNT_EN, run 3 full periods of N=2 after reset -> PCNT=3.
